// File: rtl/hilo_muldiv.sv
// HI/LO register file with a single-busy-cycle multiplier and a 32-step restoring divider.
// Results are written to HI/LO on the edge that closes the MUL or FIX cycle.
//
// state  | meaning
// S_IDLE | waiting for an issue; MTHI/MTLO write here without going busy
// S_MUL  | product of latched operands; write-back at this edge
// S_DIV  | one restoring step per cycle, 32 steps
// S_FIX  | sign correction (or divide-by-zero result); write-back at this edge
module hilo_muldiv (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        flush,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  state_t      state_q, state_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] quot_q, quot_d;
  logic [31:0] rem_q, rem_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        signed_q, signed_d;
  logic        qsign_q, qsign_d;
  logic        rsign_q, rsign_d;
  logic        dz_q, dz_d;

  logic [63:0] a_ext, b_ext, prod;
  logic [32:0] shifted;
  logic        trial_ge;
  logic [31:0] trial_diff;
  logic        div_signed;
  logic [31:0] mag_a, mag_b;

  // Low 64 bits of a 64x64 product of sign/zero-extended operands equal the true 32x32 product.
  assign a_ext = {{32{signed_q & a_q[31]}}, a_q};
  assign b_ext = {{32{signed_q & b_q[31]}}, b_q};
  assign prod  = a_ext * b_ext;

  // Divisor stays below 2^32, so the partial remainder always fits 32 bits after each step.
  assign shifted    = {rem_q, quot_q[31]};
  assign trial_ge   = shifted >= {1'b0, b_q};
  assign trial_diff = shifted[31:0] - b_q;

  assign div_signed = (op == OP_DIV);
  assign mag_a = (div_signed && src_a[31]) ? (~src_a + 32'd1) : src_a;
  assign mag_b = (div_signed && src_b[31]) ? (~src_b + 32'd1) : src_b;

  always_comb begin
    state_d  = state_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    a_d      = a_q;
    b_d      = b_q;
    quot_d   = quot_q;
    rem_d    = rem_q;
    cnt_d    = cnt_q;
    signed_d = signed_q;
    qsign_d  = qsign_q;
    rsign_d  = rsign_q;
    dz_d     = dz_q;
    done     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start && !flush) begin
          case (op)
            OP_MTHI: hi_d = src_a;
            OP_MTLO: lo_d = src_a;
            OP_MULT, OP_MULTU: begin
              a_d      = src_a;
              b_d      = src_b;
              signed_d = (op == OP_MULT);
              state_d  = S_MUL;
            end
            OP_DIV, OP_DIVU: begin
              a_d     = src_a;
              b_d     = mag_b;
              quot_d  = mag_a;
              rem_d   = 32'd0;
              cnt_d   = 5'd0;
              qsign_d = div_signed & (src_a[31] ^ src_b[31]);
              rsign_d = div_signed & src_a[31];
              dz_d    = (src_b == 32'd0);
              state_d = S_DIV;
            end
            default: ;
          endcase
        end
      end
      S_MUL: begin
        done    = 1'b1;
        hi_d    = prod[63:32];
        lo_d    = prod[31:0];
        state_d = S_IDLE;
      end
      S_DIV: begin
        rem_d  = trial_ge ? trial_diff : shifted[31:0];
        quot_d = {quot_q[30:0], trial_ge};
        cnt_d  = cnt_q + 5'd1;
        if (cnt_q == 5'd31) state_d = S_FIX;
      end
      S_FIX: begin
        done = 1'b1;
        if (dz_q) begin
          lo_d = 32'hFFFF_FFFF;
          hi_d = a_q;
        end else begin
          lo_d = qsign_q ? (~quot_q + 32'd1) : quot_q;
          hi_d = rsign_q ? (~rem_q + 32'd1) : rem_q;
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // A kill discards any pending write-back, including an issue in the same cycle.
    if (flush) begin
      state_d = S_IDLE;
      cnt_d   = 5'd0;
      hi_d    = hi_q;
      lo_d    = lo_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      a_q      <= 32'd0;
      b_q      <= 32'd0;
      quot_q   <= 32'd0;
      rem_q    <= 32'd0;
      cnt_q    <= 5'd0;
      signed_q <= 1'b0;
      qsign_q  <= 1'b0;
      rsign_q  <= 1'b0;
      dz_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      a_q      <= a_d;
      b_q      <= b_d;
      quot_q   <= quot_d;
      rem_q    <= rem_d;
      cnt_q    <= cnt_d;
      signed_q <= signed_d;
      qsign_q  <= qsign_d;
      rsign_q  <= rsign_d;
      dz_q     <= dz_d;
    end
  end

  assign busy = (state_q != S_IDLE);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_hilo_muldiv.sv
// Scoreboard bench for hilo_muldiv: issued MULT/DIV ops push expected HI/LO and busy length;
// a monitor pops on each done pulse and checks the result the following cycle.
module tb_hilo_muldiv;

  logic        clk = 1'b0;
  logic        resetn, start, flush;
  logic [2:0]  op;
  logic [31:0] src_a, src_b;
  logic        busy, done;
  logic [31:0] hi, lo;

  hilo_muldiv dut (
    .clk(clk), .resetn(resetn), .start(start), .op(op),
    .src_a(src_a), .src_b(src_b), .flush(flush),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: done (not killed) -> pop expected, compare busy length now and HI/LO next cycle.
  initial begin
    exp_t cur;
    int   busy_cnt = 0;
    bit   pend = 0;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        busy_cnt = 0;
        pend     = 0;
      end else begin
        if (pend) begin
          check("result_hi", hi, cur.hi);
          check("result_lo", lo, cur.lo);
          check("busy_after_wb", {31'd0, busy}, 32'd0);
          pend = 0;
        end
        if (busy) busy_cnt++;
        if (done && !flush) begin
          check("done_while_busy", {31'd0, busy}, 32'd1);
          if (q.size() == 0) begin
            check("unexpected_done", 32'd1, 32'd0);
          end else begin
            cur = q.pop_front();
            check("busy_cycles", busy_cnt, cur.cyc);
            pend = 1;
          end
        end
        if (!busy) busy_cnt = 0;
      end
    end
  end

  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; op = o; src_a = a; src_b = b;
    @(posedge clk); #1;
    start = 1'b0; op = 3'd0;
  endtask

  task automatic push(input logic [31:0] h, input logic [31:0] l, input int c);
    exp_t e;
    e.hi = h; e.lo = l; e.cyc = c;
    q.push_back(e);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!busy) break;
    end
    check("idle_timeout", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    int held;
    resetn = 1'b0; start = 1'b0; flush = 1'b0; op = 3'd0; src_a = 32'd0; src_b = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    @(posedge clk); #1;
    resetn = 1'b1;
    @(posedge clk); #1;

    // Preload, then reset in the middle of a divide.
    issue(3'd5, 32'hAAAA_0000, 32'd0);
    issue(3'd6, 32'h0000_5555, 32'd0);
    issue(3'd4, 32'd100, 32'd7);
    repeat (9) begin @(posedge clk); #1; end
    resetn = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
    @(negedge clk);
    check("rst_mid_busy", {31'd0, busy}, 32'd0);
    check("rst_mid_hi", hi, 32'd0);
    check("rst_mid_lo", lo, 32'd0);
    @(posedge clk); #1;

    issue(3'd6, 32'h1234, 32'd0);
    @(negedge clk);
    check("mtlo_lo", lo, 32'h1234);
    check("mtlo_busy", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("mtlo_busy2", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;

    // Multiplies: signedness matters on all-ones operands.
    push(32'hFFFF_FFFF, 32'hFFFF_FFEB, 1); issue(3'd1, 32'hFFFF_FFFD, 32'd7);          wait_idle();
    push(32'h0000_0001, 32'hFFFF_FFFE, 1); issue(3'd2, 32'hFFFF_FFFF, 32'd2);          wait_idle();
    push(32'h0000_0000, 32'h0000_0001, 1); issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF); wait_idle();
    push(32'hFFFF_FFFE, 32'h0000_0001, 1); issue(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF); wait_idle();
    push(32'h4000_0000, 32'h0000_0000, 1); issue(3'd1, 32'h8000_0000, 32'h8000_0000); wait_idle();

    // Divides, including divide-by-zero and the most-negative overflow case.
    push(32'hFFFF_FFFF, 32'hFFFF_FFFD, 33); issue(3'd3, 32'hFFFF_FFF9, 32'd2);          wait_idle();
    push(32'd2,         32'd14,        33); issue(3'd4, 32'd100, 32'd7);                wait_idle();
    push(32'd5,         32'hFFFF_FFFF, 33); issue(3'd4, 32'd5, 32'd0);                  wait_idle();
    push(32'hFFFF_FFFB, 32'hFFFF_FFFF, 33); issue(3'd3, 32'hFFFF_FFFB, 32'd0);          wait_idle();
    push(32'd0,         32'h8000_0000, 33); issue(3'd3, 32'h8000_0000, 32'hFFFF_FFFF); wait_idle();
    push(32'd1,         32'hFFFF_FFFC, 33); issue(3'd3, 32'd9, 32'hFFFF_FFFE);          wait_idle();
    push(32'hFFFF_FFFF, 32'd4,         33); issue(3'd3, 32'hFFFF_FFF7, 32'hFFFF_FFFE); wait_idle();
    push(32'h0000_0001, 32'h7FFF_FFFF, 33); issue(3'd4, 32'hFFFF_FFFF, 32'd2);          wait_idle();

    // Kill in the FIX cycle: HI/LO keep their preloaded values.
    issue(3'd5, 32'd1, 32'd0);
    issue(3'd6, 32'd2, 32'd0);
    issue(3'd3, 32'd100, 32'd7);
    repeat (32) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(negedge clk);
    check("fix_cycle_done", {31'd0, done}, 32'd1);
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    check("flush_busy", {31'd0, busy}, 32'd0);
    check("flush_hi", hi, 32'd1);
    check("flush_lo", lo, 32'd2);
    @(posedge clk); #1;

    // MULT held during a divide is accepted only once busy drops.
    push(32'd2, 32'd14, 33);
    push(32'd0, 32'd15, 1);
    issue(3'd4, 32'd100, 32'd7);
    start = 1'b1; op = 3'd1; src_a = 32'd3; src_b = 32'd5;
    held = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (!busy) break;
      held++;
    end
    check("held_busy_cycles", held, 33);
    @(posedge clk); #1;
    start = 1'b0; op = 3'd0;
    wait_idle();

    // Flush with MTHI in IDLE is ignored.
    flush = 1'b1;
    issue(3'd5, 32'h5555_5555, 32'd0);
    flush = 1'b0;
    @(negedge clk);
    check("flush_mthi_hi", hi, 32'd0);
    check("flush_mthi_busy", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;

    for (int i = 0; i < 50; i++) begin
      if (q.size() == 0) break;
      @(posedge clk);
    end
    repeat (3) @(posedge clk);
    check("scoreboard_empty", q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
